// File: rtl/cccp_pkt_gen.sv
// Purpose : builds one 9-word CCCP request frame per accepted request
//           (module hdr, Ethernet hdr, name HI/LO, VN, flags, seq, padding).
// Latency : first word is registered one cycle after accept, then one word
//           per cycle while out_rdy is high.
// Backpressure: out_rdy low at an edge holds the current beat and drops
//           out_wr; req_ready is low for the whole frame.
// Ports   : clk/reset_n           clock, async active-low reset
//           req_*                 request handshake and frame fields
//           out_data/ctrl/wr/rdy  64-bit datapath toward the output queues
//           seq_num               sequence number for the next request
//           pkt_sent              count of fully transmitted frames
module cccp_pkt_gen #(
   parameter int          DATA_WIDTH  = 64,
   parameter int          CTRL_WIDTH  = DATA_WIDTH/8,
   parameter int          NUM_QUEUES  = 8,
   parameter int          NAME_LENTH  = 32,
   parameter int          VN_LENTH    = 16,
   parameter logic [47:0] SRC_MAC     = 48'h00_4E_46_32_43_00,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter logic [15:0] SRC_PORT_ID = 16'h0000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NAME_LENTH-1:0] req_name,
   input  logic [VN_LENTH-1:0]   req_vn,
   input  logic [15:0]           req_flags,
   input  logic [NUM_QUEUES-1:0] req_oq,
   input  logic [47:0]           req_dst_mac,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   output logic [15:0]           seq_num,
   output logic [31:0]           pkt_sent
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SEND   = 1'b1;
   localparam logic [3:0] LAST_BEAT = 4'd8;

   logic [0:0]            state_q, state_d;
   logic [3:0]            beat_q, beat_d;
   logic [NAME_LENTH-1:0] name_q, name_d;
   logic [VN_LENTH-1:0]   vn_q, vn_d;
   logic [15:0]           flags_q, flags_d;
   logic [NUM_QUEUES-1:0] oq_q, oq_d;
   logic [47:0]           dst_q, dst_d;
   logic [15:0]           seqf_q, seqf_d;
   logic [15:0]           seq_q, seq_d;
   logic [31:0]           pkt_q, pkt_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
   logic                  out_wr_q, out_wr_d;

   logic [DATA_WIDTH-1:0] beat_dat;
   logic [CTRL_WIDTH-1:0] beat_ctl;
   logic [15:0]           oq_ext;

   assign req_ready = (state_q == ST_IDLE);
   assign out_data  = out_data_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_wr    = out_wr_q;
   assign seq_num   = seq_q;
   assign pkt_sent  = pkt_q;

   assign oq_ext = {{(16-NUM_QUEUES){1'b0}}, oq_q};

   // Word for the current beat, built from the latched request fields.
   always_comb begin
      beat_dat = '0;
      beat_ctl = '0;
      case (beat_q)
         4'd0: begin
            beat_ctl = {CTRL_WIDTH{1'b1}};
            beat_dat = {oq_ext, 16'd8, SRC_PORT_ID, 16'd60};
         end
         4'd1: beat_dat = {dst_q, SRC_MAC[47:32]};
         4'd2: beat_dat = {SRC_MAC[31:0], ETHERTYPE, name_q[31:16]};
         4'd3: beat_dat = {name_q[15:0], vn_q, flags_q, seqf_q};
         4'd8: beat_ctl = CTRL_WIDTH'(8'h10);   // last word, 4 valid bytes
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      name_d     = name_q;
      vn_d       = vn_q;
      flags_d    = flags_q;
      oq_d       = oq_q;
      dst_d      = dst_q;
      seqf_d     = seqf_q;
      seq_d      = seq_q;
      pkt_d      = pkt_q;
      out_data_d = out_data_q;
      out_ctrl_d = out_ctrl_q;
      out_wr_d   = 1'b0;
      if (state_q == ST_IDLE) begin
         if (req_valid) begin
            name_d  = req_name;
            vn_d    = req_vn;
            flags_d = req_flags;
            oq_d    = req_oq;
            dst_d   = req_dst_mac;
            seqf_d  = seq_q;
            seq_d   = seq_q + 16'd1;
            beat_d  = 4'd0;
            state_d = ST_SEND;
         end
      end else if (out_rdy) begin
         out_data_d = beat_dat;
         out_ctrl_d = beat_ctl;
         out_wr_d   = 1'b1;
         if (beat_q == LAST_BEAT) begin
            beat_d  = 4'd0;
            pkt_d   = pkt_q + 32'd1;
            state_d = ST_IDLE;
         end else begin
            beat_d = beat_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         name_q     <= '0;
         vn_q       <= '0;
         flags_q    <= '0;
         oq_q       <= '0;
         dst_q      <= '0;
         seqf_q     <= '0;
         seq_q      <= '0;
         pkt_q      <= '0;
         out_data_q <= '0;
         out_ctrl_q <= '0;
         out_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         name_q     <= name_d;
         vn_q       <= vn_d;
         flags_q    <= flags_d;
         oq_q       <= oq_d;
         dst_q      <= dst_d;
         seqf_q     <= seqf_d;
         seq_q      <= seq_d;
         pkt_q      <= pkt_d;
         out_data_q <= out_data_d;
         out_ctrl_q <= out_ctrl_d;
         out_wr_q   <= out_wr_d;
      end
   end

endmodule
